alib_extmem_reader: RTL and testbench

AXI4 read master that fetches one block from external memory at `base + blockAddress*16` and returns its 64-bit payload to the requesting logic.
- Mirror of the external-memory block writer; uses the same address mapping, AXI port naming and done/error semantics.
- Sits between ALFA extension logic and the PS/DDR interconnect on a dedicated read port.
- Supports single-beat or short INCR bursts; each received beat is streamed out and the last one is held as the block payload.

---
 rtl/alib_extmem_reader.sv | 160 ++++++++++++++++
 tb/tb_alib_extmem_reader.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alib_extmem_reader.sv
// AXI4 read master: fetches one block at base + blockAddress*16 and returns its
// 64-bit payload, streaming every accepted beat and holding the last one.
module alib_extmem_reader #(
   parameter int BURST_LEN = 1
) (
   input  logic        M_AXI_ACLK,
   input  logic        M_AXI_ARESET,
   input  logic [20:0] i_blockAddress,
   input  logic [31:0] i_alib_extmem_base_addr,
   input  logic        i_initReadTxn,
   output logic [63:0] o_blockPayload,
   output logic        o_beatValid,
   output logic        o_readTxnDone,
   output logic        o_busy,
   output logic        o_error,
   output logic [5:0]  M_AXI_ARID,
   output logic [31:0] M_AXI_ARADDR,
   output logic [7:0]  M_AXI_ARLEN,
   output logic [2:0]  M_AXI_ARSIZE,
   output logic [1:0]  M_AXI_ARBURST,
   output logic        M_AXI_ARLOCK,
   output logic [3:0]  M_AXI_ARCACHE,
   output logic [2:0]  M_AXI_ARPROT,
   output logic [3:0]  M_AXI_ARQOS,
   output logic        M_AXI_ARVALID,
   input  logic        M_AXI_ARREADY,
   input  logic        M_AXI_RID,
   input  logic [63:0] M_AXI_RDATA,
   input  logic [1:0]  M_AXI_RRESP,
   input  logic        M_AXI_RLAST,
   input  logic        M_AXI_RVALID,
   output logic        M_AXI_RREADY
);

   localparam logic [4:0] BEATS = 5'(BURST_LEN);

   typedef enum logic [1:0] {
      IDLE,
      ADDR,
      DATA
   } state_t;

   state_t      state_reg, state_next;
   logic        arvalid_reg, arvalid_next;
   logic        rready_reg, rready_next;
   logic        beat_valid_reg, beat_valid_next;
   logic        done_reg, done_next;
   logic        error_reg, error_next;
   logic [31:0] araddr_reg, araddr_next;
   logic [63:0] payload_reg, payload_next;
   logic [4:0]  beat_cnt_reg, beat_cnt_next;

   logic        r_fire;
   logic [4:0]  beat_num;
   logic        beat_err;

   assign r_fire   = M_AXI_RVALID & rready_reg;
   // beat_num is the 1-based index of the beat now on the bus
   assign beat_num = beat_cnt_reg + 5'd1;
   assign beat_err = (M_AXI_RRESP != 2'b00) | M_AXI_RID
                   | (M_AXI_RLAST & (beat_num != BEATS))
                   | (~M_AXI_RLAST & (beat_num >= BEATS));

   always_comb begin
      state_next      = state_reg;
      arvalid_next    = arvalid_reg;
      rready_next     = rready_reg;
      beat_valid_next = 1'b0;
      done_next       = done_reg;
      error_next      = error_reg;
      araddr_next     = araddr_reg;
      payload_next    = payload_reg;
      beat_cnt_next   = beat_cnt_reg;
      case (state_reg)
         IDLE: begin
            if (i_initReadTxn) begin
               araddr_next   = i_alib_extmem_base_addr + {7'b0, i_blockAddress, 4'b0000};
               done_next     = 1'b0;
               error_next    = 1'b0;
               beat_cnt_next = 5'd0;
               arvalid_next  = 1'b1;
               state_next    = ADDR;
            end
         end
         ADDR: begin
            if (arvalid_reg && M_AXI_ARREADY) begin
               arvalid_next = 1'b0;
               rready_next  = 1'b1;
               state_next   = DATA;
            end
         end
         DATA: begin
            if (r_fire) begin
               payload_next    = M_AXI_RDATA;
               beat_valid_next = 1'b1;
               if (beat_cnt_reg != BEATS) begin
                  beat_cnt_next = beat_num;
               end
               if (beat_err) begin
                  error_next = 1'b1;
               end
               // a malformed burst still runs to RLAST so the interconnect is drained
               if (M_AXI_RLAST) begin
                  rready_next = 1'b0;
                  done_next   = 1'b1;
                  state_next  = IDLE;
               end
            end
         end
         default: begin
            arvalid_next = 1'b0;
            rready_next  = 1'b0;
            state_next   = IDLE;
         end
      endcase
   end

   always_ff @(posedge M_AXI_ACLK or posedge M_AXI_ARESET) begin
      if (M_AXI_ARESET) begin
         state_reg      <= IDLE;
         arvalid_reg    <= 1'b0;
         rready_reg     <= 1'b0;
         beat_valid_reg <= 1'b0;
         done_reg       <= 1'b0;
         error_reg      <= 1'b0;
         araddr_reg     <= 32'd0;
         payload_reg    <= 64'd0;
         beat_cnt_reg   <= 5'd0;
      end else begin
         state_reg      <= state_next;
         arvalid_reg    <= arvalid_next;
         rready_reg     <= rready_next;
         beat_valid_reg <= beat_valid_next;
         done_reg       <= done_next;
         error_reg      <= error_next;
         araddr_reg     <= araddr_next;
         payload_reg    <= payload_next;
         beat_cnt_reg   <= beat_cnt_next;
      end
   end

   assign o_blockPayload = payload_reg;
   assign o_beatValid    = beat_valid_reg;
   assign o_readTxnDone  = done_reg;
   assign o_busy         = (state_reg != IDLE);
   assign o_error        = error_reg;

   assign M_AXI_ARID    = 6'd0;
   assign M_AXI_ARADDR  = araddr_reg;
   assign M_AXI_ARLEN   = 8'(BURST_LEN - 1);
   assign M_AXI_ARSIZE  = 3'b011;
   assign M_AXI_ARBURST = 2'b01;
   assign M_AXI_ARLOCK  = 1'b0;
   assign M_AXI_ARCACHE = 4'd0;
   assign M_AXI_ARPROT  = 3'd0;
   assign M_AXI_ARQOS   = 4'd0;
   assign M_AXI_ARVALID = arvalid_reg;
   assign M_AXI_RREADY  = rready_reg;

endmodule

// File: tb/tb_alib_extmem_reader.sv
// Bench for alib_extmem_reader: one single-beat and one 4-beat instance share
// the same stimulus; a queue scoreboard checks each against a burst-level model.
module tb_alib_extmem_reader;

   logic        clk = 1'b0;
   logic        rst;
   logic [20:0] blk;
   logic [31:0] base;
   logic        start, arready, rid, rlast, rvalid;
   logic [63:0] rdata;
   logic [1:0]  rresp;

   logic [63:0] pay4, pay1;
   logic        bv4, bv1, done4, done1, busy4, busy1, err4, err1;
   logic [5:0]  arid4, arid1;
   logic [31:0] araddr4, araddr1;
   logic [7:0]  arlen4, arlen1;
   logic [2:0]  arsize4, arsize1, arprot4, arprot1;
   logic [1:0]  arburst4, arburst1;
   logic        arlock4, arlock1, arvalid4, arvalid1, rready4, rready1;
   logic [3:0]  arcache4, arcache1, arqos4, arqos1;

   typedef struct {
      logic        err;
      logic [63:0] pay;
   } done_t;

   logic [31:0] ar_q[$];
   logic [63:0] beat_q4[$], beat_q1[$];
   done_t       done_q4[$], done_q1[$];

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   alib_extmem_reader #(.BURST_LEN(4)) u_dut4 (
      .M_AXI_ACLK(clk), .M_AXI_ARESET(rst), .i_blockAddress(blk),
      .i_alib_extmem_base_addr(base), .i_initReadTxn(start),
      .o_blockPayload(pay4), .o_beatValid(bv4), .o_readTxnDone(done4),
      .o_busy(busy4), .o_error(err4), .M_AXI_ARID(arid4), .M_AXI_ARADDR(araddr4),
      .M_AXI_ARLEN(arlen4), .M_AXI_ARSIZE(arsize4), .M_AXI_ARBURST(arburst4),
      .M_AXI_ARLOCK(arlock4), .M_AXI_ARCACHE(arcache4), .M_AXI_ARPROT(arprot4),
      .M_AXI_ARQOS(arqos4), .M_AXI_ARVALID(arvalid4), .M_AXI_ARREADY(arready),
      .M_AXI_RID(rid), .M_AXI_RDATA(rdata), .M_AXI_RRESP(rresp),
      .M_AXI_RLAST(rlast), .M_AXI_RVALID(rvalid), .M_AXI_RREADY(rready4)
   );

   alib_extmem_reader #(.BURST_LEN(1)) u_dut1 (
      .M_AXI_ACLK(clk), .M_AXI_ARESET(rst), .i_blockAddress(blk),
      .i_alib_extmem_base_addr(base), .i_initReadTxn(start),
      .o_blockPayload(pay1), .o_beatValid(bv1), .o_readTxnDone(done1),
      .o_busy(busy1), .o_error(err1), .M_AXI_ARID(arid1), .M_AXI_ARADDR(araddr1),
      .M_AXI_ARLEN(arlen1), .M_AXI_ARSIZE(arsize1), .M_AXI_ARBURST(arburst1),
      .M_AXI_ARLOCK(arlock1), .M_AXI_ARCACHE(arcache1), .M_AXI_ARPROT(arprot1),
      .M_AXI_ARQOS(arqos1), .M_AXI_ARVALID(arvalid1), .M_AXI_ARREADY(arready),
      .M_AXI_RID(rid), .M_AXI_RDATA(rdata), .M_AXI_RRESP(rresp),
      .M_AXI_RLAST(rlast), .M_AXI_RVALID(rvalid), .M_AXI_RREADY(rready1)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic fail_now(input string name);
      checks++;
      errors++;
      $display("FAIL %s: unexpected event or timeout", name);
   endtask

   // ---------------- monitors ----------------
   logic        done4_prev, done1_prev, arv_prev, ardy_prev;
   logic [31:0] araddr_prev;

   always @(negedge clk) begin
      if (rst) begin
         done4_prev <= 1'b0;
         done1_prev <= 1'b0;
         arv_prev   <= 1'b0;
         ardy_prev  <= 1'b0;
      end else begin
         if (bv4) begin
            if (beat_q4.size() == 0) fail_now("beat4_spurious");
            else check("beat4_payload", pay4, beat_q4.pop_front());
         end
         if (bv1) begin
            if (beat_q1.size() == 0) fail_now("beat1_spurious");
            else check("beat1_payload", pay1, beat_q1.pop_front());
         end
         if (done4 && !done4_prev) begin
            if (done_q4.size() == 0) fail_now("done4_spurious");
            else begin
               done_t e;
               e = done_q4.pop_front();
               check("done4_error", 64'(err4), 64'(e.err));
               check("done4_payload", pay4, e.pay);
            end
         end
         if (done1 && !done1_prev) begin
            if (done_q1.size() == 0) fail_now("done1_spurious");
            else begin
               done_t e;
               e = done_q1.pop_front();
               check("done1_error", 64'(err1), 64'(e.err));
               check("done1_payload", pay1, e.pay);
            end
         end
         if (arvalid4 && arready) begin
            if (ar_q.size() == 0) fail_now("ar_spurious");
            else begin
               logic [31:0] a;
               a = ar_q.pop_front();
               check("araddr4", 64'(araddr4), 64'(a));
               check("araddr1", 64'(araddr1), 64'(a));
               check("arlen4", 64'(arlen4), 64'd3);
               check("arlen1", 64'(arlen1), 64'd0);
               check("arsize_burst", 64'({arsize4, arburst4, arsize1, arburst1}), 64'(10'b011_01_011_01));
               check("ar_zero_fields", 64'({arid4, arlock4, arcache4, arprot4, arqos4,
                                            arid1, arlock1, arcache1, arprot1, arqos1}), 64'd0);
            end
         end
         if (arv_prev && !ardy_prev) begin
            check("arvalid_held", 64'(arvalid4), 64'd1);
            check("araddr_stable", 64'(araddr4), 64'(araddr_prev));
         end
         if (arv_prev && ardy_prev) check("rready_after_ar", 64'(rready4), 64'd1);
         if (arvalid4) check("rready_low_in_addr", 64'(rready4), 64'd0);
         check("handshake_match", 64'({arvalid1, rready1, busy1}), 64'({arvalid4, rready4, busy4}));
         done4_prev  <= done4;
         done1_prev  <= done1;
         arv_prev    <= arvalid4;
         ardy_prev   <= arready;
         araddr_prev <= araddr4;
      end
   end

   // ---------------- stimulus ----------------
   task automatic wait_idle();
      int n = 0;
      while (busy4 && n < 40) begin
         @(posedge clk); #1;
         n++;
      end
      if (n >= 40) fail_now("idle_timeout");
   endtask

   // nb_force=0 picks a random burst length; resp0 is forced onto beat 0 when nonzero
   task automatic run_txn(input int nb_force, input logic [1:0] resp0);
      int          nb;
      logic [63:0] dat[16];
      logic [1:0]  rs[16];
      logic        id[16];
      logic        bad;
      logic [31:0] exp_addr;

      base = $urandom;
      blk  = 21'($urandom);
      if (nb_force != 0) nb = nb_force;
      else begin
         case ($urandom_range(0, 3))
            0, 1:    nb = 4;
            2:       nb = 1;
            default: nb = $urandom_range(1, 6);
         endcase
      end
      bad = 1'b0;
      for (int i = 0; i < nb; i++) begin
         dat[i] = {$urandom, $urandom};
         rs[i]  = 2'b00;
         id[i]  = 1'b0;
         if (nb_force == 0) begin
            if ($urandom_range(0, 9) == 0) rs[i] = 2'($urandom_range(1, 3));
            if ($urandom_range(0, 19) == 0) id[i] = 1'b1;
         end
         if (i == 0 && resp0 != 2'b00) rs[i] = resp0;
         bad = bad | (rs[i] != 2'b00) | id[i];
      end
      exp_addr = base + 32'(blk) * 32'd16;
      ar_q.push_back(exp_addr);
      for (int i = 0; i < nb; i++) begin
         beat_q4.push_back(dat[i]);
         beat_q1.push_back(dat[i]);
      end
      done_q4.push_back('{err: bad || (nb != 4), pay: dat[nb-1]});
      done_q1.push_back('{err: bad || (nb != 1), pay: dat[nb-1]});

      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      check("start_clears", 64'({busy4, done4, err4, busy1, done1, err1}), 64'(6'b100_100));
      base = $urandom;
      blk  = 21'($urandom);

      repeat ($urandom_range(0, 6)) begin
         @(posedge clk); #1;
      end
      arready = 1'b1;
      @(posedge clk); #1 arready = 1'b0;

      for (int i = 0; i < nb; i++) begin
         logic inject;
         int   n;
         inject = ($urandom_range(0, 3) == 0);
         repeat ($urandom_range(0, 3)) begin
            start = inject;
            @(posedge clk); #1 start = 1'b0;
         end
         rvalid = 1'b1;
         rdata  = dat[i];
         rresp  = rs[i];
         rid    = id[i];
         rlast  = (i == nb - 1);
         start  = inject;
         n = 0;
         while (!rready4 && n < 20) begin
            @(posedge clk); #1;
            n++;
         end
         if (n >= 20) fail_now("rready_timeout");
         @(posedge clk); #1;
         rvalid = 1'b0;
         rlast  = 1'b0;
         rresp  = 2'b00;
         rid    = 1'b0;
         start  = 1'b0;
      end
      wait_idle();
      $display("txn addr=%h beats=%0d bad=%0d done4=%0d err4=%0d done1=%0d err1=%0d",
               exp_addr, nb, bad, done4, err4, done1, err1);
   endtask

   // minimum-latency path with ARREADY and RVALID tied high
   task automatic directed_latency();
      base    = 32'h1000_0000;
      blk     = 21'h00005;
      arready = 1'b1;
      rvalid  = 1'b1;
      rlast   = 1'b1;
      rdata   = 64'hDEADBEEF_01234567;
      ar_q.push_back(32'h1000_0050);
      beat_q4.push_back(64'hDEADBEEF_01234567);
      beat_q1.push_back(64'hDEADBEEF_01234567);
      done_q4.push_back('{err: 1'b1, pay: 64'hDEADBEEF_01234567});
      done_q1.push_back('{err: 1'b0, pay: 64'hDEADBEEF_01234567});
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      check("lat_c1_arvalid", 64'(arvalid1), 64'd1);
      check("lat_c1_araddr", 64'(araddr1), 64'h1000_0050);
      check("lat_c1_rready", 64'(rready1), 64'd0);
      @(posedge clk); #1;
      check("lat_c2_rready", 64'({arvalid1, rready1}), 64'b01);
      check("lat_c2_not_done", 64'(done1), 64'd0);
      @(posedge clk); #1;
      check("lat_c3_done", 64'({done1, bv1, err1}), 64'b110);
      check("lat_c3_payload", pay1, 64'hDEADBEEF_01234567);
      rvalid  = 1'b0;
      rlast   = 1'b0;
      arready = 1'b0;
      wait_idle();
      $display("txn latency addr=%h done1=%0d err1=%0d payload=%h", araddr1, done1, err1, pay1);
   endtask

   task automatic directed_reset();
      base = $urandom;
      blk  = 21'($urandom);
      ar_q.push_back(base + 32'(blk) * 32'd16);
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      arready = 1'b1;
      @(posedge clk); #1 arready = 1'b0;
      @(posedge clk); #1;
      check("pre_reset_rready", 64'({rready4, busy4}), 64'b11);
      @(negedge clk); #2 rst = 1'b1;
      #1;
      check("async_reset_ctrl", 64'({arvalid4, rready4, busy4, done4, err4, bv4,
                                     arvalid1, rready1, busy1, done1, err1, bv1}), 64'd0);
      check("async_reset_data", 64'({araddr4, araddr1}), 64'd0);
      ar_q.delete();
      beat_q4.delete();
      beat_q1.delete();
      done_q4.delete();
      done_q1.delete();
      @(negedge clk) rst = 1'b0;
      $display("txn async reset in DATA busy4=%0d rready4=%0d", busy4, rready4);
   endtask

   initial begin
      rst     = 1'b1;
      start   = 1'b0;
      arready = 1'b0;
      rvalid  = 1'b0;
      rlast   = 1'b0;
      rid     = 1'b0;
      rresp   = 2'b00;
      rdata   = 64'd0;
      base    = 32'd0;
      blk     = 21'd0;
      repeat (3) @(posedge clk);
      #1;
      check("reset_ctrl", 64'({arvalid4, rready4, busy4, done4, err4, bv4,
                               arvalid1, rready1, busy1, done1, err1, bv1}), 64'd0);
      check("reset_data", pay4 | pay1 | 64'({araddr4, araddr1}), 64'd0);
      rst = 1'b0;

      directed_latency();
      run_txn(4, 2'b00);
      run_txn(1, 2'b10);
      run_txn(1, 2'b00);
      run_txn(2, 2'b00);
      directed_reset();
      run_txn(4, 2'b00);
      for (int t = 0; t < 60; t++) run_txn(0, 2'b00);

      repeat (4) @(posedge clk);
      #1;
      check("queues_drained", 64'(ar_q.size() + beat_q4.size() + beat_q1.size()
                                  + done_q4.size() + done_q1.size()), 64'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1, "global timeout");
   end

endmodule
